// File: rtl/gumnut_alu_pkg.sv
// rtl/gumnut_alu_pkg.sv - opcode and FSM state encodings for gumnut_alu_seq
package gumnut_alu_pkg;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        ADDC = 3'd1,
        SUB  = 3'd2,
        SUBC = 3'd3,
        AND  = 3'd4,
        OR   = 3'd5,
        XOR  = 3'd6,
        MASK = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        SHL = 2'd0,
        SHR = 2'd1,
        ROL = 2'd2,
        ROR = 2'd3
    } shift_fn_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gumnut_shift_step.sv
// rtl/gumnut_shift_step.sv - combinational one-bit shift/rotate of a DATA_W-bit word
module gumnut_shift_step
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W = 8
)(
    input  logic [DATA_W-1:0] word,
    input  shift_fn_e         fn,
    output logic [DATA_W-1:0] next_word,
    output logic              bit_out
);

    // bit_out is always the bit leaving the word; for rotates it reappears at the far end
    always_comb begin
        next_word = word;
        bit_out   = 1'b0;
        case (fn)
            SHL: begin
                next_word = {word[DATA_W-2:0], 1'b0};
                bit_out   = word[DATA_W-1];
            end
            SHR: begin
                next_word = {1'b0, word[DATA_W-1:1]};
                bit_out   = word[0];
            end
            ROL: begin
                next_word = {word[DATA_W-2:0], word[DATA_W-1]};
                bit_out   = word[DATA_W-1];
            end
            ROR: begin
                next_word = {word[0], word[DATA_W-1:1]};
                bit_out   = word[0];
            end
        endcase
    end

endmodule

// File: rtl/gumnut_alu_seq.sv
// rtl/gumnut_alu_seq.sv - sequential Gumnut ALU/shifter with registered flags; GUMNUT_ALU_OVF_EN adds ovf_out/cc_v
module gumnut_alu_seq
    import gumnut_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              op_shift,
    input  logic [2:0]        alu_fn,
    input  logic [1:0]        shift_fn,
    input  logic [CNT_W-1:0]  count,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry_out,
    output logic              zero_out,
    output logic              cc_c,
    output logic              cc_z
`ifdef GUMNUT_ALU_OVF_EN
    ,
    output logic              ovf_out,
    output logic              cc_v
`endif
);

    state_e            state;
    logic [DATA_W-1:0] work;
    shift_fn_e         sh_fn;
    logic [CNT_W-1:0]  steps_left;
    logic [DATA_W:0]   alu_sum;
    logic [DATA_W-1:0] step_word;
    logic              step_bit;
    logic              accept;
    logic              start_shift;
    logic              load_now;
    logic              load_step;
    logic [DATA_W-1:0] now_result;
    logic              now_carry;

    assign in_ready    = (state == IDLE) || (state == DONE && out_ready);
    assign accept      = in_valid && in_ready;
    assign start_shift = op_shift && (count != '0);
    assign load_now    = accept && !start_shift;
    assign load_step   = (state == EXEC) && (steps_left == CNT_W'(1));

    // cc_c here is already the value left by an op handed off in this same cycle
    always_comb begin
        alu_sum = '0;
        case (alu_fn_e'(alu_fn))
            ADD:  alu_sum = {1'b0, a} + {1'b0, b};
            ADDC: alu_sum = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cc_c};
            SUB:  alu_sum = {1'b0, a} - {1'b0, b};
            SUBC: alu_sum = {1'b0, a} - {1'b0, b} - {{DATA_W{1'b0}}, cc_c};
            AND:  alu_sum = {1'b0, a & b};
            OR:   alu_sum = {1'b0, a | b};
            XOR:  alu_sum = {1'b0, a ^ b};
            MASK: alu_sum = {1'b0, a & ~b};
        endcase
    end

    // a zero-count shift completes immediately with the operand unchanged
    assign now_result = op_shift ? a : alu_sum[DATA_W-1:0];
    assign now_carry  = !op_shift && alu_sum[DATA_W];

    gumnut_shift_step #(.DATA_W(DATA_W)) u_step (
        .word      (work),
        .fn        (sh_fn),
        .next_word (step_word),
        .bit_out   (step_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            result     <= '0;
            carry_out  <= 1'b0;
            zero_out   <= 1'b0;
            cc_c       <= 1'b0;
            cc_z       <= 1'b0;
            work       <= '0;
            sh_fn      <= SHL;
            steps_left <= '0;
        end else begin
            if (state == DONE && out_ready && !in_valid) begin
                state     <= IDLE;
                out_valid <= 1'b0;
            end
            if (accept && start_shift) begin
                state      <= EXEC;
                out_valid  <= 1'b0;
                work       <= a;
                sh_fn      <= shift_fn_e'(shift_fn);
                steps_left <= count;
            end
            if (load_now) begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= now_result;
                carry_out <= now_carry;
                zero_out  <= (now_result == '0);
                cc_c      <= now_carry;
                cc_z      <= (now_result == '0);
            end
            if (state == EXEC) begin
                work       <= step_word;
                steps_left <= steps_left - CNT_W'(1);
            end
            if (load_step) begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= step_word;
                carry_out <= step_bit;
                zero_out  <= (step_word == '0);
                cc_c      <= step_bit;
                cc_z      <= (step_word == '0);
            end
        end
    end

`ifdef GUMNUT_ALU_OVF_EN
    logic alu_ovf;

    // subtraction flips b's sign so add and sub share one signed-overflow test
    assign alu_ovf = !op_shift && !alu_fn[2]
                   && (a[DATA_W-1] == (b[DATA_W-1] ^ alu_fn[1]))
                   && (alu_sum[DATA_W-1] != a[DATA_W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_out <= 1'b0;
            cc_v    <= 1'b0;
        end else if (load_now) begin
            ovf_out <= alu_ovf;
            cc_v    <= alu_ovf;
        end else if (load_step) begin
            ovf_out <= 1'b0;
            cc_v    <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_gumnut_alu_seq.sv
// tb/tb_gumnut_alu_seq.sv - self-checking bench for gumnut_alu_seq
`timescale 1ns/1ps
module tb_gumnut_alu_seq;

    localparam int W = 8;

    logic         clk, rst_n;
    logic         in_valid, in_ready, op_shift;
    logic [2:0]   alu_fn;
    logic [1:0]   shift_fn;
    logic [2:0]   count;
    logic [W-1:0] a, b, result;
    logic         out_valid, out_ready, carry_out, zero_out, cc_c, cc_z;
`ifdef GUMNUT_ALU_OVF_EN
    logic         ovf_out, cc_v;
`endif

    gumnut_alu_seq #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_shift  (op_shift),
        .alu_fn    (alu_fn),
        .shift_fn  (shift_fn),
        .count     (count),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero_out  (zero_out),
        .cc_c      (cc_c),
        .cc_z      (cc_z)
`ifdef GUMNUT_ALU_OVF_EN
        ,
        .ovf_out   (ovf_out),
        .cc_v      (cc_v)
`endif
    );

    typedef struct {
        logic [7:0] r;
        bit         c;
        bit         v;
        int         acc;
        int         lat;
        bit         seen;
    } exp_t;

    typedef struct {
        bit sh;
        int fn;
        int n;
        int av;
        int bv;
        int er;
        bit ec;
        bit ev;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[16];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    bit   model_cc = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference behaviour from whole-word integer arithmetic
    function automatic void model(input bit sh, input int fn, input int n, input int av,
                                  input int bv, input bit cin,
                                  output int r, output bit c, output bit v);
        int t, sa, sb;
        r = 0; c = 0; v = 0; t = 0;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        if (!sh) begin
            case (fn)
                0: begin t = av + bv;       sa = sa + sb;       end
                1: begin t = av + bv + cin; sa = sa + sb + cin; end
                2: begin t = av - bv;       sa = sa - sb;       end
                3: begin t = av - bv - cin; sa = sa - sb - cin; end
                4: t = av & bv;
                5: t = av | bv;
                6: t = av ^ bv;
                default: t = av & ~bv & 255;
            endcase
            r = t & 255;
            c = (t < 0) || (t > 255);
            v = (fn < 4) && (sa > 127 || sa < -128);
        end else if (n == 0) begin
            r = av;
        end else begin
            case (fn)
                0: begin r = (av << n) & 255; c = ((av >> (W - n)) & 1) != 0; end
                1: begin r = av >> n;         c = ((av >> (n - 1)) & 1) != 0; end
                2: begin r = ((av << n) | (av >> (W - n))) & 255; c = (r & 1) != 0; end
                default: begin r = ((av >> n) | (av << (W - n))) & 255; c = ((r >> 7) & 1) != 0; end
            endcase
        end
    endfunction

    task automatic issue(input bit sh, input int fn, input int n, input int av, input int bv,
                         input int er, input bit ec, input bit ev, input bit ordy);
        int mr;
        bit mc, mv;
        int t;
        @(posedge clk); #1;
        op_shift  = sh;
        alu_fn    = fn[2:0];
        shift_fn  = fn[1:0];
        count     = n[2:0];
        a         = av[7:0];
        b         = bv[7:0];
        out_ready = ordy;
        in_valid  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 40);
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk);
        model(sh, fn, n, av, bv, model_cc, mr, mc, mv);
        chk("model_result", mr, er);
        chk("model_carry", mc, ec);
        chk("model_ovf", mv, ev);
        exp_q.push_back('{r: mr[7:0], c: mc, v: mv, acc: cyc,
                          lat: (sh && n != 0) ? n + 1 : 1, seen: 1'b0});
        model_cc = mc;
        #1;
        in_valid = 1'b0;
        op_shift = 1'($urandom);
        alu_fn   = 3'($urandom);
        shift_fn = 2'($urandom);
        count    = 3'($urandom);
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, (exp_q.size() == 0) || (out_valid && out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
                        exp_q[0].seen = 1'b1;
                    end
                    chk("result", result, exp_q[0].r);
                    chk("carry_out", carry_out, exp_q[0].c);
                    chk("zero_out", zero_out, exp_q[0].r == 0);
                    chk("cc_c", cc_c, exp_q[0].c);
                    chk("cc_z", cc_z, exp_q[0].r == 0);
`ifdef GUMNUT_ALU_OVF_EN
                    chk("ovf_out", ovf_out, exp_q[0].v);
                    chk("cc_v", cc_v, exp_q[0].v);
`endif
                    if (out_ready) exp_q.delete(0);
                end
            end else if (exp_q.size() != 0 && (cyc - exp_q[0].acc) > exp_q[0].lat) begin
                chk("out_valid_late", out_valid, 1);
            end
        end
    end

    initial begin
        vecs = '{
            '{0, 0, 0, 'hF0, 'h20, 'h10, 1, 0},
            '{0, 1, 0, 'h01, 'h01, 'h03, 0, 0},
            '{0, 2, 0, 'h05, 'h05, 'h00, 0, 0},
            '{0, 2, 0, 'h03, 'h05, 'hFE, 1, 0},
            '{1, 0, 3, 'h81, 'h00, 'h08, 0, 0},
            '{1, 3, 1, 'h01, 'h00, 'h80, 1, 0},
            '{1, 2, 0, 'hA5, 'h00, 'hA5, 0, 0},
            '{1, 1, 7, 'h80, 'h00, 'h01, 0, 0},
            '{1, 2, 1, 'h81, 'h00, 'h03, 1, 0},
            '{0, 0, 0, 'h7F, 'h01, 'h80, 0, 1},
            '{0, 2, 0, 'h80, 'h01, 'h7F, 0, 1},
            '{0, 4, 0, 'hF0, 'h3C, 'h30, 0, 0},
            '{0, 0, 0, 'hFF, 'h01, 'h00, 1, 0},
            '{1, 0, 7, 'hFF, 'h00, 'h80, 1, 0},
            '{0, 3, 0, 'h00, 'h00, 'hFF, 1, 0},
            '{1, 1, 1, 'h01, 'h00, 'h00, 1, 0}
        };

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op_shift = 1'b0;
        alu_fn = '0; shift_fn = '0; count = '0; a = '0; b = '0;
        #2 rst_n = 1'b0;
        #20;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_carry_out", carry_out, 0);
        chk("rst_zero_out", zero_out, 0);
        chk("rst_cc_c", cc_c, 0);
        chk("rst_cc_z", cc_z, 0);
`ifdef GUMNUT_ALU_OVF_EN
        chk("rst_ovf_out", ovf_out, 0);
        chk("rst_cc_v", cc_v, 0);
`endif
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].sh, vecs[i].fn, vecs[i].n, vecs[i].av, vecs[i].bv,
                  vecs[i].er, vecs[i].ec, vecs[i].ev, 1'b1);
            drain();
        end

        // backpressure on mask, then handoff with same-cycle accept of xor
        issue(0, 7, 0, 'hFF, 'h0F, 'hF0, 0, 0, 0);
        repeat (5) @(negedge clk);
        issue(0, 6, 0, 'h55, 'hFF, 'hAA, 0, 0, 1);
        drain();

        // subc accepted during handoff must see the borrow of the sub being handed off
        issue(0, 2, 0, 'h03, 'h05, 'hFE, 1, 0, 0);
        repeat (2) @(negedge clk);
        issue(0, 3, 0, 'h10, 'h01, 'h0E, 0, 0, 1);
        drain();

        // shift accepted during handoff goes straight back to EXEC
        issue(0, 5, 0, 'h0F, 'hF0, 'hFF, 0, 0, 0);
        repeat (2) @(negedge clk);
        issue(1, 0, 2, 'h41, 'h00, 'h04, 1, 0, 1);
        drain();

        // reset in the middle of a 7-step shift
        issue(0, 0, 0, 'hF0, 'h20, 'h10, 1, 0, 1);
        drain();
        issue(1, 0, 7, 'h01, 'h00, 'h80, 0, 0, 1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_cc = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cc_c", cc_c, 0);
        chk("midrst_cc_z", cc_z, 0);
        chk("midrst_carry_out", carry_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("postrst_in_ready", in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("postrst_no_completion", out_valid, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
